inst_fetch: RTL

- Producer end of the instruction path: owns the PC and issues word-aligned fetch requests to instruction memory.
- Buffers returned words and presents {instruction, PC} pairs to the instruction register / decode stage with a valid/stall handshake.
- Handles branch/jump redirects by flushing buffered and in-flight fetches.
- Sits between instruction memory and the IF/ID instruction register.

---
 rtl/inst_fetch_pkg.sv | 17 +
 rtl/inst_fetch_fifo.sv | 53 +++++
 rtl/inst_fetch.sv | 112 +++++++++++
 3 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared constants and state encoding for the instruction fetch unit.
package inst_fetch_pkg;

   localparam logic [31:0] NOP_INST     = 32'h0000_0000;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
   localparam logic [31:0] PC_INC       = 32'd4;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } fetch_state_e;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & ~32'd3;
   endfunction

endpackage

// File: rtl/inst_fetch_fifo.sv
// Synchronous FIFO with synchronous clear; used for the {inst,pc} buffer and the in-flight PC queue.
module inst_fetch_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             empty_o,
   output logic [CW-1:0]    count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (clr_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push_i, pop_i})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset: the count gates every consumer of rdata_o.
   always_ff @(posedge clk) begin
      if (push_i && !clr_i) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign empty_o = (count_q == '0);
   assign count_o = count_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: owns the PC, issues word fetches, buffers responses and handles redirects.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_RUN   | normal fetching, requests issued while buffer space remains
//   ST_FLUSH | stale responses from before a redirect still being dropped
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
   parameter int          BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] out_inst,
   output logic [31:0] out_pc,
   output logic        out_valid,
   input  logic        in_stall,
   input  logic        br_taken,
   input  logic [31:0] br_target
);

   localparam int CW = $clog2(BUF_DEPTH) + 1;

   fetch_state_e  state_q, state_d;
   logic [31:0]   pc_q, pc_d;
   logic [CW-1:0] drop_cnt_q, drop_cnt_d;

   logic [CW-1:0] outstanding;
   logic [CW-1:0] buf_count;
   logic [CW:0]   reserved;
   logic          buf_empty;
   logic          pcq_empty;
   logic [63:0]   buf_rdata;
   logic [31:0]   req_pc;
   logic          fire;
   logic          rsp_keep;
   logic          buf_pop;
   logic          pcq_pop;

   // Each request reserves a buffer slot at issue time, so the buffer never overflows.
   assign reserved  = {1'b0, outstanding} + {1'b0, buf_count};
   assign imem_req  = reset && (state_q == ST_RUN) && !br_taken
                      && (reserved < (CW+1)'(BUF_DEPTH));
   assign imem_addr = pc_q;
   assign fire      = imem_req && imem_ready;

   assign pcq_pop   = imem_rvalid && !pcq_empty;
   assign rsp_keep  = imem_rvalid && (drop_cnt_q == '0) && !br_taken;
   assign out_valid = !buf_empty;
   assign buf_pop   = out_valid && !in_stall && !br_taken;

   assign out_inst  = out_valid ? buf_rdata[63:32] : NOP_INST;
   assign out_pc    = out_valid ? buf_rdata[31:0]  : 32'h0;

   inst_fetch_fifo #(.WIDTH(32), .DEPTH(BUF_DEPTH)) u_pc_queue (
      .clk     (clk),
      .reset   (reset),
      .clr_i   (1'b0),
      .push_i  (fire),
      .wdata_i (pc_q),
      .pop_i   (pcq_pop),
      .rdata_o (req_pc),
      .empty_o (pcq_empty),
      .count_o (outstanding)
   );

   inst_fetch_fifo #(.WIDTH(64), .DEPTH(BUF_DEPTH)) u_inst_buf (
      .clk     (clk),
      .reset   (reset),
      .clr_i   (br_taken),
      .push_i  (rsp_keep),
      .wdata_i ({imem_rdata, req_pc}),
      .pop_i   (buf_pop),
      .rdata_o (buf_rdata),
      .empty_o (buf_empty),
      .count_o (buf_count)
   );

   always_comb begin
      pc_d       = pc_q;
      drop_cnt_d = drop_cnt_q;
      state_d    = state_q;
      if (br_taken) begin
         pc_d       = word_align(br_target);
         // A response landing in the redirect cycle is already stale; drop it now.
         drop_cnt_d = outstanding - CW'(imem_rvalid);
      end else begin
         if (fire) pc_d = pc_q + PC_INC;
         if (imem_rvalid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - 1'b1;
      end
      state_d = (drop_cnt_d != '0) ? ST_FLUSH : ST_RUN;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_RUN;
         pc_q       <= RESET_PC;
         drop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

endmodule
